enigma_stream_decipher: RTL and testbench

- Clocked receiver-side Enigma unit. Accepts a ciphertext character stream over a valid/ready handshake and returns plaintext over a second valid/ready handshake.
- Rotor stepping is done correctly, including the middle-rotor double-step. Because the cipher is reciprocal, the same block also enciphers.
- Fixed configuration: rotors I (left), II (middle), III (right); reflector B; ring settings AAA.
- Sits after the link receiver; the start positions are loaded as the per-message key.

---
 rtl/enigma_stream_if.sv | 45 ++++
 rtl/enigma_stream_decipher.sv | 193 +++++++++++++++++++
 tb/tb_enigma_stream_decipher.sv | 286 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/enigma_stream_if.sv
// Handshake, key and status bundle for enigma_stream_decipher.
// With ENIGMA_PLUGBOARD_EN defined, the plugboard write port is carried here as well.
interface enigma_stream_if;
    logic       key_load;
    logic [4:0] key_left;
    logic [4:0] key_mid;
    logic [4:0] key_right;
    // Both streams transfer a character on a clock edge where valid && ready;
    // valid never waits on ready, and a raised valid holds its data until the transfer.
    logic       in_valid;
    logic       in_ready;
    logic [4:0] in_char;
    logic       out_valid;
    logic       out_ready;
    logic [4:0] out_char;
    logic [4:0] pos_left;
    logic [4:0] pos_mid;
    logic [4:0] pos_right;
    logic       err_char;
    logic [1:0] dbg_state;
    logic       dbg_left_notch;
`ifdef ENIGMA_PLUGBOARD_EN
    logic       pb_wr;
    logic [4:0] pb_addr;
    logic [4:0] pb_data;
`endif

    modport master (
`ifdef ENIGMA_PLUGBOARD_EN
        output pb_wr, pb_addr, pb_data,
`endif
        output key_load, key_left, key_mid, key_right, in_valid, in_char, out_ready,
        input  in_ready, out_valid, out_char, pos_left, pos_mid, pos_right, err_char,
        input  dbg_state, dbg_left_notch
    );

    modport slave (
`ifdef ENIGMA_PLUGBOARD_EN
        input  pb_wr, pb_addr, pb_data,
`endif
        input  key_load, key_left, key_mid, key_right, in_valid, in_char, out_ready,
        output in_ready, out_valid, out_char, pos_left, pos_mid, pos_right, err_char,
        output dbg_state, dbg_left_notch
    );
endinterface

// File: rtl/enigma_stream_decipher.sv
// Enigma I (rotors I-II-III, reflector B, rings AAA) stream cipher with double-step stepping.
// Optional plugboard enabled by defining ENIGMA_PLUGBOARD_EN.
module enigma_stream_decipher #(
    parameter int unsigned NOTCH_R = 21,
    parameter int unsigned NOTCH_M = 4,
    parameter int unsigned NOTCH_L = 16
) (
    input logic            clk,
    input logic            rst_n,
    enigma_stream_if.slave bus
);
    typedef enum logic [1:0] {IDLE = 2'd0, STEP = 2'd1, MAP = 2'd2, HOLD = 2'd3} state_e;

    localparam logic [4:0]   NR       = 5'(NOTCH_R);
    localparam logic [4:0]   NM       = 5'(NOTCH_M);
    localparam logic [4:0]   NL       = 5'(NOTCH_L);
    localparam logic [4:0]   SPACE    = 5'd31;
    localparam logic [207:0] ROT_I    = "EKMFLGDQVZNTOWYHXUSPAIBRCJ";
    localparam logic [207:0] ROT_II   = "AJDKSIRUXBLHWTMCQGZNPYFVOE";
    localparam logic [207:0] ROT_III  = "BDFHJLCPRTXVZNYEIWGAKMUSQO";
    localparam logic [207:0] REFL_B   = "YRUHQSLDPXNGOKMIEBFZCWVJAT";

    state_e     state_q, state_d;
    logic [4:0] pos_l_q, pos_l_d;
    logic [4:0] pos_m_q, pos_m_d;
    logic [4:0] pos_r_q, pos_r_d;
    logic [4:0] char_q, char_d;
    logic [4:0] out_char_q, out_char_d;
    logic       err_q, err_d;
    logic [4:0] pb_entry, path_out, pb_exit;

    function automatic logic [4:0] wire_at(input logic [207:0] w, input logic [4:0] i);
        logic [7:0] c;
        c = w[8*(25-int'(i)) +: 8];
        return 5'(c - 8'd65);
    endfunction

    function automatic logic [4:0] inv_at(input logic [207:0] w, input logic [4:0] y);
        logic [4:0] r;
        r = 5'd0;
        for (int k = 0; k < 26; k++) begin
            if (wire_at(w, 5'(k)) == y) r = 5'(k);
        end
        return r;
    endfunction

    function automatic logic [4:0] add26(input logic [4:0] a, input logic [4:0] b);
        logic [5:0] s;
        s = {1'b0, a} + {1'b0, b};
        if (s >= 6'd26) s = s - 6'd26;
        return s[4:0];
    endfunction

    // A negative 6-bit difference has bit 5 set; one add of 26 brings it back into range.
    function automatic logic [4:0] sub26(input logic [4:0] a, input logic [4:0] b);
        logic [5:0] s;
        s = {1'b0, a} - {1'b0, b};
        if (s[5]) s = s + 6'd26;
        return s[4:0];
    endfunction

    function automatic logic [4:0] fwd(input logic [207:0] w, input logic [4:0] x, input logic [4:0] p);
        return sub26(wire_at(w, add26(x, p)), p);
    endfunction

    function automatic logic [4:0] bwd(input logic [207:0] w, input logic [4:0] x, input logic [4:0] p);
        return sub26(inv_at(w, add26(x, p)), p);
    endfunction

    function automatic logic [4:0] inc26(input logic [4:0] v);
        return (v == 5'd25) ? 5'd0 : v + 5'd1;
    endfunction

    function automatic logic [4:0] key26(input logic [4:0] k);
        return (k > 5'd25) ? k - 5'd26 : k;
    endfunction

    always_comb begin
        logic [4:0] t;
        t = fwd(ROT_III, pb_entry, pos_r_q);
        t = fwd(ROT_II,  t,        pos_m_q);
        t = fwd(ROT_I,   t,        pos_l_q);
        t = wire_at(REFL_B, t);
        t = bwd(ROT_I,   t,        pos_l_q);
        t = bwd(ROT_II,  t,        pos_m_q);
        t = bwd(ROT_III, t,        pos_r_q);
        path_out = t;
    end

`ifdef ENIGMA_PLUGBOARD_EN
    logic [4:0] pb_q [26];
    logic [4:0] pb_d [26];

    always_comb begin
        pb_d = pb_q;
        if (bus.pb_wr && state_q == IDLE && bus.pb_addr <= 5'd25 && bus.pb_data <= 5'd25) begin
            pb_d[bus.pb_addr] = bus.pb_data;
            pb_d[bus.pb_data] = bus.pb_addr;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 26; i++) pb_q[i] <= 5'(i);
        end else begin
            pb_q <= pb_d;
        end
    end

    assign pb_entry = pb_q[char_q];
    assign pb_exit  = pb_q[path_out];
`else
    assign pb_entry = char_q;
    assign pb_exit  = path_out;
`endif

    always_comb begin
        state_d    = state_q;
        pos_l_d    = pos_l_q;
        pos_m_d    = pos_m_q;
        pos_r_d    = pos_r_q;
        char_d     = char_q;
        out_char_d = out_char_q;
        err_d      = 1'b0;
        // A key load wins over everything and drops whatever character is in flight.
        if (bus.key_load) begin
            pos_l_d = key26(bus.key_left);
            pos_m_d = key26(bus.key_mid);
            pos_r_d = key26(bus.key_right);
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE: begin
                    if (bus.in_valid) begin
                        if (bus.in_char <= 5'd25) begin
                            char_d  = bus.in_char;
                            state_d = STEP;
                        end else if (bus.in_char == SPACE) begin
                            out_char_d = SPACE;
                            state_d    = HOLD;
                        end else begin
                            err_d = 1'b1;
                        end
                    end
                end
                STEP: begin
                    pos_r_d = inc26(pos_r_q);
                    if (pos_r_q == NR || pos_m_q == NM) pos_m_d = inc26(pos_m_q);
                    if (pos_m_q == NM) pos_l_d = inc26(pos_l_q);
                    state_d = MAP;
                end
                MAP: begin
                    out_char_d = pb_exit;
                    state_d    = HOLD;
                end
                HOLD: begin
                    if (bus.out_ready) state_d = IDLE;
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            pos_l_q    <= 5'd0;
            pos_m_q    <= 5'd0;
            pos_r_q    <= 5'd0;
            char_q     <= 5'd0;
            out_char_q <= 5'd0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            pos_l_q    <= pos_l_d;
            pos_m_q    <= pos_m_d;
            pos_r_q    <= pos_r_d;
            char_q     <= char_d;
            out_char_q <= out_char_d;
            err_q      <= err_d;
        end
    end

    assign bus.in_ready       = (state_q == IDLE);
    assign bus.out_valid      = (state_q == HOLD);
    assign bus.out_char       = out_char_q;
    assign bus.pos_left       = pos_l_q;
    assign bus.pos_mid        = pos_m_q;
    assign bus.pos_right      = pos_r_q;
    assign bus.err_char       = err_q;
    assign bus.dbg_state      = state_q;
    assign bus.dbg_left_notch = (pos_l_q == NL);
endmodule

// File: tb/tb_enigma_stream_decipher.sv
// Self-checking bench for enigma_stream_decipher: golden vectors, corner sequences and
// randomized traffic checked against a table-based Enigma model.
module tb_enigma_stream_decipher;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    enigma_stream_if bus();
    enigma_stream_decipher dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    int checks = 0;
    int errors = 0;
    logic [4:0] exp_q[$];

    int fw[3][26];
    int bw[3][26];
    int refl[26];
    int ml, mm, mr;

    typedef struct {
        bit         load;
        logic [4:0] kl, km, kr, ch;
        bit         chk_out;
        logic [4:0] exp_out, exp_l, exp_m, exp_r;
    } vec_t;
    vec_t vecs[14];

    function automatic vec_t mk(bit load, int kl, int km, int kr, int ch, bit chk, int eo, int el, int em, int er);
        vec_t v;
        v.load = load; v.kl = 5'(kl); v.km = 5'(km); v.kr = 5'(kr); v.ch = 5'(ch);
        v.chk_out = chk; v.exp_out = 5'(eo); v.exp_l = 5'(el); v.exp_m = 5'(em); v.exp_r = 5'(er);
        return v;
    endfunction

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic build_tables();
        string s[4];
        s[0] = "EKMFLGDQVZNTOWYHXUSPAIBRCJ";
        s[1] = "AJDKSIRUXBLHWTMCQGZNPYFVOE";
        s[2] = "BDFHJLCPRTXVZNYEIWGAKMUSQO";
        s[3] = "YRUHQSLDPXNGOKMIEBFZCWVJAT";
        for (int r = 0; r < 3; r++) begin
            for (int i = 0; i < 26; i++) begin
                fw[r][i] = int'(s[r].getc(i)) - 65;
                bw[r][fw[r][i]] = i;
            end
        end
        for (int i = 0; i < 26; i++) refl[i] = int'(s[3].getc(i)) - 65;
    endtask

    function automatic int through(int r, int x, int p, bit inv);
        int e;
        e = (x + p) % 26;
        return ((inv ? bw[r][e] : fw[r][e]) - p + 26) % 26;
    endfunction

    function automatic int model_cipher(int c);
        int x;
        x = through(2, c, mr, 0);
        x = through(1, x, mm, 0);
        x = through(0, x, ml, 0);
        x = refl[x];
        x = through(0, x, ml, 1);
        x = through(1, x, mm, 1);
        return through(2, x, mr, 1);
    endfunction

    task automatic model_step();
        bit turn_m, turn_l;
        turn_m = (mr == 21) || (mm == 4);
        turn_l = (mm == 4);
        mr = (mr + 1) % 26;
        if (turn_m) mm = (mm + 1) % 26;
        if (turn_l) ml = (ml + 1) % 26;
    endtask

    task automatic check_pos(input string name);
        check({name, "_pos_l"}, bus.pos_left, ml);
        check({name, "_pos_m"}, bus.pos_mid, mm);
        check({name, "_pos_r"}, bus.pos_right, mr);
    endtask

    task automatic load_key(input logic [4:0] l, input logic [4:0] m, input logic [4:0] r);
        bus.key_load = 1'b1;
        bus.key_left = l; bus.key_mid = m; bus.key_right = r;
        @(negedge clk);
        bus.key_load = 1'b0;
        ml = (l > 25) ? l - 26 : l;
        mm = (m > 25) ? m - 26 : m;
        mr = (r > 25) ? r - 26 : r;
        check_pos("key");
    endtask

    task automatic do_char(input logic [4:0] c, input int hold, output logic [4:0] got);
        int n;
        logic [4:0] e;
        got = 5'd0;
        bus.out_ready = 1'b0;
        check("in_ready_idle", bus.in_ready, 1);
        bus.in_valid = 1'b1;
        bus.in_char = c;
        @(negedge clk);
        bus.in_valid = 1'b0;
        if (c >= 26 && c <= 30) begin
            check("err_pulse", bus.err_char, 1);
            check("err_no_valid", bus.out_valid, 0);
            @(negedge clk);
            check("err_clear", bus.err_char, 0);
            check("err_no_valid2", bus.out_valid, 0);
            check_pos("err");
            return;
        end
        if (c <= 25) begin
            model_step();
            exp_q.push_back(5'(model_cipher(c)));
        end else begin
            exp_q.push_back(5'd31);
        end
        n = 1;
        while (!bus.out_valid && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("latency", n, (c == 31) ? 1 : 3);
        e = exp_q.pop_front();
        if (!bus.out_valid) return;
        got = bus.out_char;
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            check("hold_stable", bus.out_char, got);
            check("hold_valid", bus.out_valid, 1);
            check("hold_in_ready", bus.in_ready, 0);
        end
        check("out_char", got, e);
        check_pos("out");
        bus.out_ready = 1'b1;
        @(negedge clk);
        bus.out_ready = 1'b0;
        check("out_done", bus.out_valid, 0);
        check("ready_again", bus.in_ready, 1);
    endtask

    initial begin
        logic [4:0] got;
        bit saw_valid;
        build_tables();
        bus.key_load = 0; bus.key_left = 0; bus.key_mid = 0; bus.key_right = 0;
        bus.in_valid = 0; bus.in_char = 0; bus.out_ready = 0;
`ifdef ENIGMA_PLUGBOARD_EN
        bus.pb_wr = 0; bus.pb_addr = 0; bus.pb_data = 0;
`endif
        ml = 0; mm = 0; mr = 0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("rst_pos_l", bus.pos_left, 0);
        check("rst_pos_m", bus.pos_mid, 0);
        check("rst_pos_r", bus.pos_right, 0);
        check("rst_out_valid", bus.out_valid, 0);
        check("rst_out_char", bus.out_char, 0);
        check("rst_err", bus.err_char, 0);
        check("rst_in_ready", bus.in_ready, 1);
        check("rst_state", bus.dbg_state, 0);

        vecs[0]  = mk(1, 0, 0, 0,  0, 1, 1,  0, 0, 1);
        vecs[1]  = mk(0, 0, 0, 0,  0, 1, 3,  0, 0, 2);
        vecs[2]  = mk(0, 0, 0, 0,  0, 1, 25, 0, 0, 3);
        vecs[3]  = mk(0, 0, 0, 0,  0, 1, 6,  0, 0, 4);
        vecs[4]  = mk(0, 0, 0, 0,  0, 1, 14, 0, 0, 5);
        vecs[5]  = mk(1, 0, 0, 0,  1, 1, 0,  0, 0, 1);
        vecs[6]  = mk(0, 0, 0, 0,  3, 1, 0,  0, 0, 2);
        vecs[7]  = mk(0, 0, 0, 0, 25, 1, 0,  0, 0, 3);
        vecs[8]  = mk(0, 0, 0, 0,  6, 1, 0,  0, 0, 4);
        vecs[9]  = mk(0, 0, 0, 0, 14, 1, 0,  0, 0, 5);
        vecs[10] = mk(1, 0, 3, 20, 0, 0, 0,  0, 3, 21);
        vecs[11] = mk(0, 0, 0, 0,  7, 0, 0,  0, 4, 22);
        vecs[12] = mk(0, 0, 0, 0, 11, 0, 0,  1, 5, 23);
        vecs[13] = mk(0, 0, 0, 0, 19, 0, 0,  1, 5, 24);
        for (int i = 0; i < 14; i++) begin
            if (vecs[i].load) load_key(vecs[i].kl, vecs[i].km, vecs[i].kr);
            do_char(vecs[i].ch, 0, got);
            if (vecs[i].chk_out) check("vec_out", got, vecs[i].exp_out);
            check("vec_pos_l", bus.pos_left, vecs[i].exp_l);
            check("vec_pos_m", bus.pos_mid, vecs[i].exp_m);
            check("vec_pos_r", bus.pos_right, vecs[i].exp_r);
        end

        // Space passes through without stepping; an invalid code only pulses err_char.
        load_key(0, 0, 0);
        do_char(5'd31, 0, got);
        check("space_out", got, 31);
        check("space_pos_r", bus.pos_right, 0);
        do_char(5'd28, 0, got);
        check("inval_pos_r", bus.pos_right, 0);

        // Backpressure for 10 cycles, then the next character is accepted normally.
        do_char(5'd7, 10, got);
        do_char(5'd8, 0, got);

        // Key values above 25 wrap by one subtraction of 26.
        load_key(5'd31, 5'd26, 5'd30);
        check("keywrap_l", bus.pos_left, 5);
        check("keywrap_m", bus.pos_mid, 0);
        check("keywrap_r", bus.pos_right, 4);

        // key_load during MAP drops the character.
        load_key(0, 0, 0);
        bus.in_valid = 1'b1; bus.in_char = 5'd0;
        @(negedge clk);
        bus.in_valid = 1'b0;
        @(negedge clk);
        bus.key_load = 1'b1; bus.key_left = 25; bus.key_mid = 25; bus.key_right = 25;
        @(negedge clk);
        bus.key_load = 1'b0;
        ml = 25; mm = 25; mr = 25;
        check("abort_state", bus.dbg_state, 0);
        check("abort_in_ready", bus.in_ready, 1);
        saw_valid = bus.out_valid;
        repeat (4) begin
            @(negedge clk);
            saw_valid |= bus.out_valid;
        end
        check("abort_no_out", saw_valid, 0);
        check_pos("abort");
        do_char(5'd0, 0, got);
        check("zzz_pos_l", bus.pos_left, 25);
        check("zzz_pos_m", bus.pos_mid, 25);
        check("zzz_pos_r", bus.pos_right, 0);

        // key_load beats a simultaneous in_valid.
        bus.key_load = 1'b1; bus.key_left = 1; bus.key_mid = 2; bus.key_right = 3;
        bus.in_valid = 1'b1; bus.in_char = 5'd5;
        @(negedge clk);
        bus.key_load = 1'b0; bus.in_valid = 1'b0;
        ml = 1; mm = 2; mr = 3;
        saw_valid = 1'b0;
        repeat (4) begin
            check("prio_state", bus.dbg_state, 0);
            saw_valid |= bus.out_valid;
            @(negedge clk);
        end
        check("prio_no_out", saw_valid, 0);
        check_pos("prio");

        // Asynchronous reset during MAP clears everything at once.
        bus.in_valid = 1'b1; bus.in_char = 5'd9;
        @(negedge clk);
        bus.in_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("arst_valid", bus.out_valid, 0);
        check("arst_pos_r", bus.pos_right, 0);
        check("arst_pos_m", bus.pos_mid, 0);
        check("arst_ready", bus.in_ready, 1);
        @(negedge clk);
        rst_n = 1'b1;
        ml = 0; mm = 0; mr = 0;
        @(negedge clk);
        check_pos("arst");

        for (int i = 0; i < 200; i++) begin
            int r;
            logic [4:0] c;
            r = $urandom_range(0, 19);
            if (r == 0) begin
                load_key(5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)));
            end else begin
                if (r == 1) c = 5'd31;
                else if (r == 2) c = 5'($urandom_range(26, 30));
                else c = 5'($urandom_range(0, 25));
                do_char(c, ($urandom_range(0, 3) == 0) ? $urandom_range(1, 4) : 0, got);
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
